// File: rtl/all_high_event_counter.sv
// all_high_event_counter
// Consumes the AND4 "all inputs high" level. The level is synchronised into
// clk_sys-domain-style flops, then debounced in both directions. Each
// accepted rise produces a single-cycle pulse and bumps a saturating counter.
// A sticky flag records any increment that was lost at full scale.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LOW     | filtered level low, waiting for a synchronised high sample
// QUAL    | counting consecutive high samples toward STABLE_CYCLES
// HIGH    | filtered level high, waiting for a synchronised low sample
// RELEASE | counting consecutive low samples toward STABLE_CYCLES
module all_high_event_counter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0,
  input  logic                 en,
  input  logic                 clr,
  output logic                 out_pulse,
  output logic                 filt,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int QW = $clog2(STABLE_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_ONE  = QW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    QUAL    = 2'd1,
    HIGH    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [QW-1:0]          qual_cnt;
  logic                   rise_accept;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in0};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A rise is accepted on the edge where the final qualifying high sample
  // lands; the counter reacts on that same edge as the pulse register.
  always_comb begin
    rise_accept = 1'b0;
    if (s) begin
      if (state == LOW && STABLE_CYCLES == 1) begin
        rise_accept = 1'b1;
      end else if (state == QUAL && qual_cnt == QUAL_LAST) begin
        rise_accept = 1'b1;
      end
    end
  end

  // Debounce FSM with registered pulse and filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOW;
      qual_cnt  <= '0;
      out_pulse <= 1'b0;
      filt      <= 1'b0;
    end else begin
      out_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              state     <= HIGH;
              qual_cnt  <= '0;
              out_pulse <= 1'b1;
              filt      <= 1'b1;
            end else begin
              state    <= QUAL;
              qual_cnt <= QUAL_ONE;
            end
          end
        end
        QUAL: begin
          if (!s) begin
            state    <= LOW;
            qual_cnt <= '0;
          end else if (qual_cnt == QUAL_LAST) begin
            state     <= HIGH;
            qual_cnt  <= '0;
            out_pulse <= 1'b1;
            filt      <= 1'b1;
          end else begin
            qual_cnt <= qual_cnt + QUAL_ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              state    <= LOW;
              qual_cnt <= '0;
              filt     <= 1'b0;
            end else begin
              state    <= RELEASE;
              qual_cnt <= QUAL_ONE;
            end
          end
        end
        RELEASE: begin
          if (s) begin
            state    <= HIGH;
            qual_cnt <= '0;
          end else if (qual_cnt == QUAL_LAST) begin
            state    <= LOW;
            qual_cnt <= '0;
            filt     <= 1'b0;
          end else begin
            qual_cnt <= qual_cnt + QUAL_ONE;
          end
        end
        default: begin
          state    <= LOW;
          qual_cnt <= '0;
          filt     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating event counter; clear takes priority over a coincident event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (rise_accept && en) begin
      if (count == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_all_high_event_counter.sv
// Directed bench for all_high_event_counter (CNT_WIDTH=2 so saturation is
// reachable). Stimulus pushes the expected pulse cycle/count/overflow into a
// queue; a monitor pops and compares whenever out_pulse is seen.
module tb_all_high_event_counter;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in0 = 1'b0;
  logic          en  = 1'b1;
  logic          clr = 1'b0;
  logic          out_pulse;
  logic          filt;
  logic [CW-1:0] count;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  all_high_event_counter #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in0      (in0),
    .en       (en),
    .clr      (clr),
    .out_pulse(out_pulse),
    .filt     (filt),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every observed pulse with the oldest expectation and
  // flag expectations whose cycle has passed without a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_pulse_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (out_pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", int'(count), e.cnt);
          check("pulse_ovf", int'(overflow), e.ovf);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Clean event of hi edges; optional clr on the pulse edge.
  task automatic clean_event(input int hi, input int ecnt, input int eovf, input bit clr_at_pulse);
    int k;
    k = cyc + 1;
    in0 = 1'b1;
    exp_q.push_back('{k + 5, ecnt, eovf});
    if (clr_at_pulse) begin
      wait_cyc(k + 4);
      clr = 1'b1;
      wait_cyc(k + 5);
      clr = 1'b0;
    end
    wait_cyc(k + hi - 1);
    in0 = 1'b0;
    wait_cyc(k + hi + 6);
  endtask

  initial begin
    int k;
    int r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pulse", int'(out_pulse), 0);
    check("rst_filt", int'(filt), 0);
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(overflow), 0);

    // clean event with filt window checks
    k = cyc + 1;
    in0 = 1'b1;
    exp_q.push_back('{k + 5, 1, 0});
    wait_cyc(k + 4);
    check("clean_filt_before", int'(filt), 0);
    wait_cyc(k + 5);
    check("clean_filt_rise", int'(filt), 1);
    wait_cyc(k + 9);
    in0 = 1'b0;
    wait_cyc(k + 14);
    check("clean_filt_last", int'(filt), 1);
    wait_cyc(k + 15);
    check("clean_filt_fall", int'(filt), 0);
    check("clean_count", int'(count), 1);
    wait_cyc(k + 18);

    // rise glitch: 3 high cycles must not qualify
    in0 = 1'b1;
    repeat (3) @(negedge clk);
    in0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rglitch_filt", int'(filt), 0);
    end
    check("rglitch_count", int'(count), 1);

    // fall glitch: 3 low cycles inside HIGH must not release
    k = cyc + 1;
    in0 = 1'b1;
    exp_q.push_back('{k + 5, 2, 0});
    wait_cyc(k + 8);
    in0 = 1'b0;
    wait_cyc(k + 11);
    in0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("fglitch_filt", int'(filt), 1);
    end
    in0 = 1'b0;
    repeat (8) @(negedge clk);
    check("fglitch_filt_low", int'(filt), 0);
    check("fglitch_count", int'(count), 2);

    // en=0: pulse still produced, count holds
    en = 1'b0;
    clean_event(6, 2, 0, 1'b0);
    en = 1'b1;
    check("en0_count", int'(count), 2);

    // clr coincident with pulse: event lost
    clean_event(6, 0, 0, 1'b1);
    check("clr_pulse_count", int'(count), 0);

    // saturation at max=3
    clean_event(6, 1, 0, 1'b0);
    clean_event(6, 2, 0, 1'b0);
    clean_event(6, 3, 0, 1'b0);
    clean_event(6, 3, 1, 1'b0);
    clean_event(6, 3, 1, 1'b0);
    check("sat_count", int'(count), 3);
    check("sat_ovf", int'(overflow), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_count", int'(count), 0);
    check("clr_ovf", int'(overflow), 0);
    @(negedge clk);
    check("clr_hold_count", int'(count), 0);

    // one event so reset has a nonzero count to clear
    clean_event(6, 1, 0, 1'b0);

    // reset asserted mid-cycle while qualifying
    k = cyc + 1;
    in0 = 1'b1;
    wait_cyc(k + 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_filt", int'(filt), 0);
    check("async_rst_pulse", int'(out_pulse), 0);
    check("async_rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back('{r + 6, 1, 0});
    wait_cyc(r + 5);
    check("requal_filt_early", int'(filt), 0);
    wait_cyc(r + 8);
    check("requal_filt", int'(filt), 1);
    in0 = 1'b0;
    repeat (10) @(negedge clk);

    check("pending_pulses", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
